// File: rtl/mem_access_pkg.sv
// Shared definitions for the load/store unit: funct3 codes, FSM states,
// byte-enable patterns and the alignment rule.
package mem_access_pkg;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2
    } state_t;

    // Unknown funct3 codes fall back to word size, so they inherit word alignment.
    function automatic logic misaligned_f(input logic is_store, input logic [2:0] f3,
                                          input logic [1:0] lo);
        logic res;
        res = 1'b0;
        if (is_store) begin
            case (f3)
                F3_SB:   res = 1'b0;
                F3_SH:   res = lo[0];
                default: res = (lo != 2'b00);
            endcase
        end else begin
            case (f3)
                F3_LB, F3_LBU: res = 1'b0;
                F3_LH, F3_LHU: res = lo[0];
                default:       res = (lo != 2'b00);
            endcase
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// Combinational lane logic: byte enables and lane replication on the request
// side, lane selection and sign/zero extension on the load-return side.
module mem_lsu_align
    import mem_access_pkg::*;
(
    input  logic [2:0]  req_funct3,
    input  logic        req_store,
    input  logic [1:0]  req_addr_lo,
    input  logic [31:0] req_wdata,
    output logic [3:0]  req_be,
    output logic [31:0] req_lane_data,
    output logic        req_misaligned,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Request side: enables and replicated store data sized by funct3.
    always_comb begin
        req_be        = BE_WORD;
        req_lane_data = req_wdata;
        if (req_store) begin
            case (req_funct3)
                F3_SB: begin
                    req_be        = BE_BYTE << req_addr_lo;
                    req_lane_data = {4{req_wdata[7:0]}};
                end
                F3_SH: begin
                    req_be        = BE_HALF << {req_addr_lo[1], 1'b0};
                    req_lane_data = {2{req_wdata[15:0]}};
                end
                default: begin
                    req_be        = BE_WORD;
                    req_lane_data = req_wdata;
                end
            endcase
        end else begin
            case (req_funct3)
                F3_LB, F3_LBU: req_be = BE_BYTE << req_addr_lo;
                F3_LH, F3_LHU: req_be = BE_HALF << {req_addr_lo[1], 1'b0};
                default:       req_be = BE_WORD;
            endcase
        end
    end

    assign req_misaligned = misaligned_f(req_store, req_funct3, req_addr_lo);

    // Load side: pick the addressed lane of the returned word.
    always_comb begin
        byte_s = ld_rdata[7:0];
        case (ld_addr_lo)
            2'd0:    byte_s = ld_rdata[7:0];
            2'd1:    byte_s = ld_rdata[15:8];
            2'd2:    byte_s = ld_rdata[23:16];
            2'd3:    byte_s = ld_rdata[31:24];
            default: byte_s = ld_rdata[7:0];
        endcase
        if (ld_addr_lo[1]) begin
            half_s = ld_rdata[31:16];
        end else begin
            half_s = ld_rdata[15:0];
        end
    end

    // Load side: extend the selected lane according to funct3.
    always_comb begin
        ld_data = ld_rdata;
        case (ld_funct3)
            F3_LB:   ld_data = {{24{byte_s[7]}}, byte_s};
            F3_LBU:  ld_data = {24'd0, byte_s};
            F3_LH:   ld_data = {{16{half_s[15]}}, half_s};
            F3_LHU:  ld_data = {16'd0, half_s};
            default: ld_data = ld_rdata;
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// Memory-access stage: passes ALU results to write-back and runs loads/stores
// over a request/grant data bus with a separate read-data-valid return.
module mem_access
    import mem_access_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid_i,
    input  logic        mem_r_ena_i,
    input  logic        mem_w_ena_i,
    input  logic [31:0] mem_r_addr_i,
    input  logic [31:0] mem_w_addr_i,
    input  logic [31:0] mem_w_data_i,
    input  logic [31:0] inst_i,
    input  logic        reg_w_ena_i,
    input  logic [4:0]  reg_w_addr_i,
    input  logic [31:0] reg_w_data_i,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_be_o,
    input  logic        bus_gnt_i,
    input  logic        bus_rvalid_i,
    input  logic [31:0] bus_rdata_i,
    output logic        wb_valid_o,
    output logic        wb_reg_w_ena_o,
    output logic [4:0]  wb_reg_w_addr_o,
    output logic [31:0] wb_reg_w_data_o,
    output logic        hold_o,
    output logic        misalign_o
);

    state_t      state_r;
    logic        bus_req_r, bus_we_r;
    logic [31:0] bus_addr_r, bus_wdata_r;
    logic [3:0]  bus_be_r;
    logic        wb_valid_r, wb_reg_w_ena_r, misalign_r;
    logic [4:0]  wb_reg_w_addr_r;
    logic [31:0] wb_reg_w_data_r;
    logic [2:0]  ld_f3_r;
    logic [1:0]  ld_lo_r;
    logic        pend_ena_r;
    logic [4:0]  pend_addr_r;

    logic        mem_op_s, is_store_s, misaligned_s, hold_s;
    logic [2:0]  funct3_s;
    logic [31:0] req_addr_s, lane_wdata_s, ld_data_s;
    logic [3:0]  be_s;
    logic        unused_s;

    assign funct3_s   = inst_i[14:12];
    assign mem_op_s   = mem_r_ena_i | mem_w_ena_i;
    assign is_store_s = mem_w_ena_i;
    assign unused_s   = ^{inst_i[31:15], inst_i[11:0]};

    // A store takes the address port whenever both enables are raised.
    always_comb begin
        if (is_store_s) begin
            req_addr_s = mem_w_addr_i;
        end else begin
            req_addr_s = mem_r_addr_i;
        end
    end

    mem_lsu_align u_align (
        .req_funct3     (funct3_s),
        .req_store      (is_store_s),
        .req_addr_lo    (req_addr_s[1:0]),
        .req_wdata      (mem_w_data_i),
        .req_be         (be_s),
        .req_lane_data  (lane_wdata_s),
        .req_misaligned (misaligned_s),
        .ld_funct3      (ld_f3_r),
        .ld_addr_lo     (ld_lo_r),
        .ld_rdata       (bus_rdata_i),
        .ld_data        (ld_data_s)
    );

    // Stall request; forced low during reset so upstream sees an idle stage.
    always_comb begin
        hold_s = 1'b0;
        if (rst) begin
            hold_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    hold_s = ex_valid_i & mem_op_s & ~misaligned_s;
                REQ:     hold_s = ~(bus_gnt_i & bus_we_r);
                WAIT_R:  hold_s = ~bus_rvalid_i;
                default: hold_s = 1'b0;
            endcase
        end
    end

    // Access FSM with registered bus and write-back outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r         <= IDLE;
            bus_req_r       <= 1'b0;
            bus_we_r        <= 1'b0;
            bus_addr_r      <= 32'd0;
            bus_wdata_r     <= 32'd0;
            bus_be_r        <= 4'd0;
            wb_valid_r      <= 1'b0;
            wb_reg_w_ena_r  <= 1'b0;
            wb_reg_w_addr_r <= 5'd0;
            wb_reg_w_data_r <= 32'd0;
            misalign_r      <= 1'b0;
            ld_f3_r         <= 3'd0;
            ld_lo_r         <= 2'd0;
            pend_ena_r      <= 1'b0;
            pend_addr_r     <= 5'd0;
        end else begin
            wb_valid_r     <= 1'b0;
            wb_reg_w_ena_r <= 1'b0;
            misalign_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (ex_valid_i && mem_op_s && misaligned_s) begin
                        misalign_r <= 1'b1;
                        wb_valid_r <= 1'b1;
                    end else if (ex_valid_i && mem_op_s) begin
                        state_r     <= REQ;
                        bus_req_r   <= 1'b1;
                        bus_we_r    <= is_store_s;
                        bus_addr_r  <= {req_addr_s[31:2], 2'b00};
                        bus_wdata_r <= lane_wdata_s;
                        bus_be_r    <= be_s;
                        ld_f3_r     <= funct3_s;
                        ld_lo_r     <= req_addr_s[1:0];
                        pend_ena_r  <= reg_w_ena_i;
                        pend_addr_r <= reg_w_addr_i;
                    end else if (ex_valid_i) begin
                        wb_valid_r      <= 1'b1;
                        wb_reg_w_ena_r  <= reg_w_ena_i;
                        wb_reg_w_addr_r <= reg_w_addr_i;
                        wb_reg_w_data_r <= reg_w_data_i;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus_gnt_i) begin
                        bus_req_r <= 1'b0;
                        bus_we_r  <= 1'b0;
                        if (bus_we_r) begin
                            wb_valid_r <= 1'b1;
                            state_r    <= IDLE;
                        end else begin
                            state_r <= WAIT_R;
                        end
                    end else begin
                        state_r <= REQ;
                    end
                end
                WAIT_R: begin
                    if (bus_rvalid_i) begin
                        wb_valid_r      <= 1'b1;
                        wb_reg_w_ena_r  <= pend_ena_r;
                        wb_reg_w_addr_r <= pend_addr_r;
                        wb_reg_w_data_r <= ld_data_s;
                        state_r         <= IDLE;
                    end else begin
                        state_r <= WAIT_R;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end

    assign bus_req_o       = bus_req_r;
    assign bus_we_o        = bus_we_r;
    assign bus_addr_o      = bus_addr_r;
    assign bus_wdata_o     = bus_wdata_r;
    assign bus_be_o        = bus_be_r;
    assign wb_valid_o      = wb_valid_r;
    assign wb_reg_w_ena_o  = wb_reg_w_ena_r;
    assign wb_reg_w_addr_o = wb_reg_w_addr_r;
    assign wb_reg_w_data_o = wb_reg_w_data_r;
    assign misalign_o      = misalign_r;
    assign hold_o          = hold_s;

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 Parameters (name, default, meaning): none; all widths come from the shared define file (32-bit data and address, 5-bit register address).
REQ-002 Clock and reset: one clock; reset is synchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  synchronous active-high reset.
REQ-005 ex_valid_i  in  1  execute-side outputs are valid this cycle.
REQ-006 mem_r_ena_i / mem_w_ena_i  in  1/1  load / store request.
REQ-007 mem_r_addr_i / mem_w_addr_i  in  32/32  load / store byte address.
REQ-008 mem_w_data_i  in  32  store data, right-aligned.
REQ-009 inst_i  in  32  instruction; funct3 = inst_i[14:12] selects access size.
REQ-010 reg_w_ena_i / reg_w_addr_i / reg_w_data_i  in  1/5/32  register write from execute.
REQ-011 bus_req_o / bus_we_o  out  1/1  data-bus request / write.
REQ-012 bus_addr_o / bus_wdata_o / bus_be_o  out  32/32/4  word address, lane data, byte enables.
REQ-013 bus_gnt_i / bus_rvalid_i / bus_rdata_i  in  1/1/32  grant, read-data valid, read word.
REQ-014 wb_valid_o / wb_reg_w_ena_o / wb_reg_w_addr_o / wb_reg_w_data_o  out  1/1/5/32  write-back result.
REQ-015 hold_o  out  1  stall request; upstream holds inputs stable while high.
REQ-016 misalign_o  out  1  one-cycle misaligned-access pulse.

Function
REQ-017 FSM states SHALL be IDLE, REQ, WAIT_R.
REQ-018 IDLE, ex_valid_i with no memory request: register the reg_w_* inputs to wb_* with wb_valid_o=1 on the next cycle (1-cycle latency).
REQ-019 IDLE, aligned load or store: go to REQ with bus_req_o=1 from the next cycle.
REQ-020 bus_req_o, bus_we_o, bus_addr_o, bus_wdata_o and bus_be_o SHALL stay stable in REQ until a cycle with bus_gnt_i=1.
REQ-021 REQ with bus_gnt_i, store: bus_req_o=0, wb_valid_o=1 with wb_reg_w_ena_o=0 next cycle, then IDLE.
REQ-022 REQ with bus_gnt_i, load: go to WAIT_R.
REQ-023 WAIT_R with bus_rvalid_i: next cycle wb_valid_o=1 with extracted data, then IDLE.
REQ-024 bus_rvalid_i outside WAIT_R SHALL be ignored.
REQ-025 bus_addr_o SHALL equal {addr[31:2],2'b00}.
REQ-026 Store enables: SB = 4'b0001<<addr[1:0]; SH = 4'b0011<<{addr[1],1'b0}; SW = 4'b1111.
REQ-027 Store data: byte replicated on all 4 lanes for SB, halfword on both halves for SH.
REQ-028 Load extraction: LB/LBU and LH/LHU select the lane from addr[1:0], sign- or zero-extended; LW passes the word.
REQ-029 Undefined load funct3 SHALL be treated as LW; undefined store funct3 as SW.
REQ-030 Misaligned access (LH/LHU/SH with addr[0]=1; LW/SW with addr[1:0]!=0): no bus request; misalign_o=1 and wb_valid_o=1 with wb_reg_w_ena_o=0 for one cycle.
REQ-031 mem_r_ena_i and mem_w_ena_i both high: the store wins.
REQ-032 hold_o SHALL be combinational and high when: IDLE accepting an aligned memory op; REQ except a store being granted; WAIT_R without bus_rvalid_i.
REQ-033 wb_valid_o and misalign_o SHALL be single-cycle pulses per instruction.

Reset
REQ-034 rst high at a clock edge SHALL force IDLE and zero every output register; in-flight transactions are abandoned.
REQ-035 Combinational outputs SHALL reflect the IDLE state during reset, so hold_o=0.

Structure
REQ-036 The shared define file SHALL hold the load/store funct3 codes, the FSM state encodings and the BE_* constants.
REQ-037 The combinational sub-module mem_lsu_align SHALL contain lane selection, sign extension, store replication and byte-enable generation; the FSM stays in mem_access.

Verification
REQ-038 LB at 0x1003, rdata 0x80FF_1234, gnt and rvalid each 1 cycle late -> bus_addr 0x1000, wb_reg_w_data 0xFFFF_FF80; hold_o high until the rvalid cycle.
REQ-039 SH at 0x2002, data 0x0000_ABCD -> bus_be 4'b1100, bus_wdata 0xABCD_ABCD, wb_reg_w_ena_o=0.
REQ-040 LW at 0x3001 -> no bus_req_o, misalign_o pulse, wb_reg_w_ena_o=0.
REQ-041 ADD result 0x5 to x7 -> wb_valid_o=1, wb_reg_w_addr_o=7, wb_reg_w_data_o=0x5 one cycle later; hold_o stays 0.
REQ-042 bus_gnt_i held low for 5 cycles -> bus_req_o and address stable for all 5 cycles; hold_o=1 throughout.
REQ-043 rst asserted in WAIT_R, then a late bus_rvalid_i -> all outputs 0, FSM IDLE, no wb_valid_o.
